// File: rtl/io_port_decoder.sv
// -----------------------------------------------------------------------------
// io_port_decoder
//
// Registered I/O port decoder for the CPU I/O bus. Each of NUM_PORTS address
// windows is described by a base/mask pair. An access starts on the rising
// edge of ioread or iowrite. It then steps through a small FSM:
//   IDLE -> ACTIVE (chip select asserted, per-port wait states counted)
//        -> STROBE (one-cycle read or write strobe, io_ready raised)
//        -> HOLD   (io_ready and chip select held until both requests drop)
// An unmatched request, or a request where read and write are both high,
// goes straight to HOLD. It raises io_ready without a chip select or strobe,
// so the CPU never stalls on an empty address.
//
// Optional feature (macro IO_UNMAPPED_DETECT_EN):
//   When the macro is defined, the outputs unmapped_err and unmapped_addr
//   are added. unmapped_err is a one-cycle pulse and unmapped_addr is the
//   latched offending address. When the macro is undefined, both ports and
//   their logic are absent.
//
// Ports:
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high reset
//   address        in   I/O address, sampled on the request edge only
//   iowrite        in   I/O write request (level)
//   ioread         in   I/O read request (level)
//   port_cs        out  one-hot registered chip select
//   port_wr_stb    out  one-cycle write strobe for the selected port
//   port_rd_stb    out  one-cycle read strobe for the selected port
//   io_ready       out  access complete, held until the request drops
//   busy           out  FSM is not in IDLE
//   unmapped_err   out  (optional) pulse on an unmatched or simultaneous request
//   unmapped_addr  out  (optional) address of the last such request
// -----------------------------------------------------------------------------
module io_port_decoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_PORTS  = 4,
    parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] PORT_BASE = {8'h20, 8'h10, 8'h00, 8'hFF},
    parameter logic [NUM_PORTS*ADDR_WIDTH-1:0] PORT_MASK = {8'hFF, 8'hF0, 8'hFE, 8'hFF},
    parameter logic [NUM_PORTS*4-1:0]          PORT_WAIT = {4'd3, 4'd0, 4'd1, 4'd0}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  iowrite,
    input  logic                  ioread,
    output logic [NUM_PORTS-1:0]  port_cs,
    output logic [NUM_PORTS-1:0]  port_wr_stb,
    output logic [NUM_PORTS-1:0]  port_rd_stb,
    output logic                  io_ready,
    output logic                  busy
`ifdef IO_UNMAPPED_DETECT_EN
    ,
    output logic                  unmapped_err,
    output logic [ADDR_WIDTH-1:0] unmapped_addr
`endif
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    // State and registered outputs
    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic                   r_dir_wr;
    logic                   r_prev_wr;
    logic                   r_prev_rd;
    logic [NUM_PORTS-1:0]   r_cs;
    logic [NUM_PORTS-1:0]   r_wr_stb;
    logic [NUM_PORTS-1:0]   r_rd_stb;
    logic                   r_ready;

    // Next-state values
    state_t                 w_state_nxt;
    logic [3:0]             w_cnt_nxt;
    logic                   w_dir_wr_nxt;
    logic [NUM_PORTS-1:0]   w_cs_nxt;
    logic [NUM_PORTS-1:0]   w_wr_stb_nxt;
    logic [NUM_PORTS-1:0]   w_rd_stb_nxt;
    logic                   w_ready_nxt;

    // Decode results
    logic                   w_match;
    logic [IDX_W-1:0]       w_match_idx;
    logic [NUM_PORTS-1:0]   w_match_onehot;
    logic [3:0]             w_match_wait;
    logic                   w_wr_edge;
    logic                   w_rd_edge;
    logic                   w_req_edge;
    logic                   w_req_both;
    logic                   w_req_active;
    logic                   w_req_none;
    logic                   w_reject;

`ifdef IO_UNMAPPED_DETECT_EN
    logic                   r_err;
    logic [ADDR_WIDTH-1:0]  r_uaddr;
    logic                   w_err_nxt;
    logic [ADDR_WIDTH-1:0]  w_uaddr_nxt;
`endif

    // The previous-request registers are reset to 1. A request that is
    // already high when reset is released therefore produces no edge.
    assign w_wr_edge  = iowrite & ~r_prev_wr;
    assign w_rd_edge  = ioread  & ~r_prev_rd;
    assign w_req_edge = w_wr_edge | w_rd_edge;
    assign w_req_both = iowrite & ioread;
    assign w_req_none = ~iowrite & ~ioread;

    // Abort watches only the request line that started the access.
    assign w_req_active = r_dir_wr ? iowrite : ioread;

    // Address window decode. The loop scans from the highest index down,
    // so on overlapping windows the lowest index is the last writer and wins.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if ((address & PORT_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (PORT_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & PORT_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                w_match     = 1'b1;
                w_match_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_match_onehot              = '0;
        w_match_onehot[w_match_idx] = 1'b1;
    end

    assign w_match_wait = PORT_WAIT[int'(w_match_idx)*4 +: 4];

    // The rejected case covers both unmatched and simultaneous requests.
    // It completes at once, without a chip select or strobe.
    assign w_reject = w_req_both | ~w_match;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dir_wr_nxt = r_dir_wr;
        w_cs_nxt     = r_cs;
        w_wr_stb_nxt = '0;
        w_rd_stb_nxt = '0;
        w_ready_nxt  = r_ready;
`ifdef IO_UNMAPPED_DETECT_EN
        w_err_nxt    = 1'b0;
        w_uaddr_nxt  = r_uaddr;
`endif

        case (r_state)
            S_IDLE: begin
                w_cs_nxt    = '0;
                w_ready_nxt = 1'b0;
                if (w_req_edge) begin
                    if (w_reject) begin
                        w_state_nxt = S_HOLD;
                        w_ready_nxt = 1'b1;
`ifdef IO_UNMAPPED_DETECT_EN
                        w_err_nxt   = 1'b1;
                        w_uaddr_nxt = address;
`endif
                    end else begin
                        w_state_nxt  = S_ACTIVE;
                        w_cs_nxt     = w_match_onehot;
                        w_cnt_nxt    = w_match_wait;
                        w_dir_wr_nxt = iowrite;
                    end
                end
            end

            S_ACTIVE: begin
                if (!w_req_active) begin
                    w_state_nxt = S_IDLE;
                    w_cs_nxt    = '0;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt = S_STROBE;
                    w_ready_nxt = 1'b1;
                    // r_cs already holds the one-hot select of the latched port.
                    if (r_dir_wr) begin
                        w_wr_stb_nxt = r_cs;
                    end else begin
                        w_rd_stb_nxt = r_cs;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end

            S_STROBE: begin
                w_state_nxt = S_HOLD;
            end

            S_HOLD: begin
                if (w_req_none) begin
                    w_state_nxt = S_IDLE;
                    w_ready_nxt = 1'b0;
                    w_cs_nxt    = '0;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cs_nxt    = '0;
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_dir_wr  <= 1'b0;
            r_prev_wr <= 1'b1;
            r_prev_rd <= 1'b1;
            r_cs      <= '0;
            r_wr_stb  <= '0;
            r_rd_stb  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dir_wr  <= w_dir_wr_nxt;
            r_prev_wr <= iowrite;
            r_prev_rd <= ioread;
            r_cs      <= w_cs_nxt;
            r_wr_stb  <= w_wr_stb_nxt;
            r_rd_stb  <= w_rd_stb_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

`ifdef IO_UNMAPPED_DETECT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err   <= 1'b0;
            r_uaddr <= '0;
        end else begin
            r_err   <= w_err_nxt;
            r_uaddr <= w_uaddr_nxt;
        end
    end

    assign unmapped_err  = r_err;
    assign unmapped_addr = r_uaddr;
`endif

    assign port_cs     = r_cs;
    assign port_wr_stb = r_wr_stb;
    assign port_rd_stb = r_rd_stb;
    assign io_ready    = r_ready;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_io_port_decoder.sv
module tb_io_port_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] address;
    logic       iowrite;
    logic       ioread;
    logic [3:0] port_cs;
    logic [3:0] port_wr_stb;
    logic [3:0] port_rd_stb;
    logic       io_ready;
    logic       busy;
`ifdef IO_UNMAPPED_DETECT_EN
    logic       unmapped_err;
    logic [7:0] unmapped_addr;
`endif

    io_port_decoder dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .iowrite     (iowrite),
        .ioread      (ioread),
        .port_cs     (port_cs),
        .port_wr_stb (port_wr_stb),
        .port_rd_stb (port_rd_stb),
        .io_ready    (io_ready),
        .busy        (busy)
`ifdef IO_UNMAPPED_DETECT_EN
        ,
        .unmapped_err  (unmapped_err),
        .unmapped_addr (unmapped_addr)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference map, written per port index as a plain table.
    int base_t[4] = '{8'hFF, 8'h00, 8'h10, 8'h20};
    int mask_t[4] = '{8'hFF, 8'hFE, 8'hF0, 8'hFF};
    int wait_t[4] = '{0, 1, 0, 3};

    typedef struct {
        int         cyc;
        logic [3:0] wr;
        logic [3:0] rd;
        logic [3:0] cs;
        logic       err;
        logic [7:0] ua;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    logic [7:0] last_ua = 8'h00;

    function automatic int decode(input logic [7:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((int'(a) & mask_t[i]) == (base_t[i] & mask_t[i])) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cyc %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every strobe, rising io_ready or error pulse is one event.
    logic prev_ready = 1'b0;
    always @(negedge clock) begin : monitor
        bit  trig;
        ev_t e;
        trig = (io_ready && !prev_ready) || (|port_wr_stb) || (|port_rd_stb);
`ifdef IO_UNMAPPED_DETECT_EN
        trig = trig || unmapped_err;
`endif
        if (trig) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event at cyc %0d: wr=%b rd=%b cs=%b ready=%b, want none",
                         cyc, port_wr_stb, port_rd_stb, port_cs, io_ready);
            end else begin
                e = exp_q.pop_front();
                check("event_cycle", cyc, e.cyc);
                check("wr_stb", {28'd0, port_wr_stb}, {28'd0, e.wr});
                check("rd_stb", {28'd0, port_rd_stb}, {28'd0, e.rd});
                check("cs_at_event", {28'd0, port_cs}, {28'd0, e.cs});
                check("ready_at_event", {31'd0, io_ready}, 32'd1);
`ifdef IO_UNMAPPED_DETECT_EN
                check("unmapped_err", {31'd0, unmapped_err}, {31'd0, e.err});
                check("unmapped_addr", {24'd0, unmapped_addr}, {24'd0, e.ua});
`endif
            end
        end
        prev_ready <= io_ready;
    end

    // One access. The request is high for h sampled edges, then released.
    // The outcome follows directly from the map: reject, success, or abort.
    task automatic run_access(input logic [7:0] a, input bit wr, input bit both, input int h,
                              input bit chg, input logic [7:0] a2, input bit pulse);
        int         p;
        int         e_cyc;
        int         w;
        bit         rej;
        bit         ok;
        logic [3:0] oh;
        ev_t        ev;
        p     = decode(a);
        rej   = both || (p < 0);
        w     = rej ? 0 : wait_t[p];
        oh    = rej ? 4'b0000 : (4'b0001 << p);
        ok    = !rej && (h >= w + 2);
        e_cyc = cyc + 1;
        address = a;
        iowrite = wr | both;
        ioread  = ~wr | both;
        if (rej) begin
            ev = '{cyc: e_cyc, wr: 4'b0, rd: 4'b0, cs: 4'b0, err: 1'b1, ua: a};
            last_ua = a;
            exp_q.push_back(ev);
        end else if (ok) begin
            ev = '{cyc: e_cyc + 1 + w, wr: wr ? oh : 4'b0, rd: wr ? 4'b0 : oh, cs: oh,
                   err: 1'b0, ua: last_ua};
            exp_q.push_back(ev);
        end
        for (int j = 0; j < h; j++) begin
            step();
            if (j == 0) begin
                check("cs_edge1", {28'd0, port_cs}, {28'd0, oh});
                check("ready_edge1", {31'd0, io_ready}, {31'd0, rej});
                check("busy_edge1", {31'd0, busy}, 32'd1);
                if (chg) address = a2;
                if (pulse && h >= 3 && !both) begin
                    if (wr) ioread = 1'b1;
                    else iowrite = 1'b1;
                end
            end
            if (j == 1 && pulse && h >= 3 && !both) begin
                if (wr) ioread = 1'b0;
                else iowrite = 1'b0;
            end
            if (j == h - 1) begin
                iowrite = 1'b0;
                ioread  = 1'b0;
            end
        end
        // The only case where the access outlives the drop edge is when the
        // drop falls on the strobe cycle: HOLD is entered and exits one clock later.
        step();
        check("cs_after_drop", {28'd0, port_cs}, (ok && h == w + 2) ? {28'd0, oh} : 32'd0);
        check("ready_after_drop", {31'd0, io_ready}, {31'd0, ok && h == w + 2});
        repeat (3) step();
        check("idle_cs", {28'd0, port_cs}, 32'd0);
        check("idle_ready", {31'd0, io_ready}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] picks[8];
        logic [7:0] a;
        logic [7:0] a2;
        picks   = '{8'hFF, 8'h00, 8'h01, 8'h10, 8'h1F, 8'h20, 8'h55, 8'h21};
        reset   = 1'b1;
        iowrite = 1'b0;
        ioread  = 1'b0;
        address = 8'h00;
        repeat (3) step();
        check("rst_cs", {28'd0, port_cs}, 32'd0);
        check("rst_wr", {28'd0, port_wr_stb}, 32'd0);
        check("rst_rd", {28'd0, port_rd_stb}, 32'd0);
        check("rst_ready", {31'd0, io_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (2) step();

        run_access(8'hFF, 1'b1, 1'b0, 6, 1'b0, 8'h00, 1'b0);
        run_access(8'h01, 1'b0, 1'b0, 5, 1'b0, 8'h00, 1'b0);
        run_access(8'h20, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0);
        run_access(8'h55, 1'b1, 1'b0, 3, 1'b0, 8'h00, 1'b0);
        run_access(8'h10, 1'b0, 1'b0, 4, 1'b1, 8'hFF, 1'b0);

        // Simultaneous edge, then reset while ioread is still held high.
        begin
            ev_t ev;
            address = 8'hFF;
            iowrite = 1'b1;
            ioread  = 1'b1;
            ev = '{cyc: cyc + 1, wr: 4'b0, rd: 4'b0, cs: 4'b0, err: 1'b1, ua: 8'hFF};
            exp_q.push_back(ev);
            repeat (2) step();
            check("both_hold_ready", {31'd0, io_ready}, 32'd1);
            check("both_hold_cs", {28'd0, port_cs}, 32'd0);
            iowrite = 1'b0;
            reset   = 1'b1;
            last_ua = 8'h00;
            repeat (2) step();
            reset = 1'b0;
            for (int k = 0; k < 5; k++) begin
                step();
                check("held_after_reset_busy", {31'd0, busy}, 32'd0);
            end
            ioread = 1'b0;
            step();
            run_access(8'hFF, 1'b0, 1'b0, 3, 1'b0, 8'h00, 1'b0);
        end

        // Reset in the middle of a wait-state access suppresses the strobe.
        address = 8'h20;
        ioread  = 1'b1;
        repeat (2) step();
        reset  = 1'b1;
        ioread = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_cs", {28'd0, port_cs}, 32'd0);
        repeat (6) step();

        for (int n = 0; n < 150; n++) begin
            a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : picks[$urandom_range(0, 7)];
            a2 = 8'($urandom);
            run_access(a, 1'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(1, 7),
                       1'($urandom), a2, 1'($urandom));
        end

        repeat (4) step();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
